// File: rtl/systolic_array_fmt_stream_if.sv
// systolic_array_fmt_stream_if: beat input, flush control and byte output
// handshakes of the systolic_array_fmt_stream tile.
// master = producer/consumer side (tile wrapper), slave = the engine.
interface systolic_array_fmt_stream_if;
    logic [1:0] fmt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_left;
    logic [7:0] in_top;
    logic       flush;
    logic       flush_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output fmt, in_valid, in_left, in_top, flush, out_ready,
        input  in_ready, flush_ready, out_valid, out_data
    );

    modport slave (
        input  fmt, in_valid, in_left, in_top, flush, out_ready,
        output in_ready, flush_ready, out_valid, out_data
    );
endinterface

// File: rtl/systolic_array_fmt_stream.sv
// systolic_array_fmt_stream: weight-stationary FP4/INT4 x INT8 tile engine.
// Beats of two 4-bit weights plus one INT8 activation fill a double buffer;
// each completed group is multiplied column by column into H*W accumulators.
// A flush snapshots the accumulators into a byte queue (shift + saturate)
// that drains over a valid/ready stream.
// Optional macro RELU_EN: output bytes clamp negative values to 0.
module systolic_array_fmt_stream #(
    parameter int SLICES    = 2,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 11
) (
    input  logic clk,
    input  logic reset,
    systolic_array_fmt_stream_if.slave bus
);
    localparam int H  = 2 * SLICES;
    localparam int W  = SLICES;
    localparam int N  = H * W;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH_WAIT,
        ST_SNAP
    } state_e;

    // Signed product of one 4-bit weight code and one INT8 activation.
    // Largest magnitude is 128 << 7, so 16 bits always hold it.
    function automatic logic signed [15:0] weight_mul(
        input logic [3:0]        w,
        input logic [1:0]        f,
        input logic signed [7:0] a
    );
        logic signed [15:0] a_x;
        logic signed [15:0] mag;
        logic signed [15:0] res;
        logic [4:0]         scale;
        a_x   = 16'(a);
        mag   = '0;
        res   = '0;
        scale = '0;
        case (f)
            2'd0: begin
                mag = (w[2:0] == 3'd0) ? '0 : (a_x <<< w[2:0]);
                res = w[3] ? -mag : mag;
            end
            2'd1: res = 16'($signed(w)) * a_x;
            2'd2: begin
                if (w[2:1] == 2'd0) scale = {4'd0, w[0]};
                else                scale = 5'({1'b1, w[0]}) << (w[2:1] - 2'd1);
                mag = a_x * $signed({11'd0, scale});
                res = w[3] ? -mag : mag;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Output stage: arithmetic shift, then clamp to a signed byte.
    function automatic logic [7:0] out_byte(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> OUT_SHIFT;
        if (s[ACC_W-1]) begin
`ifdef RELU_EN
            return 8'h00;
`else
            return (&s[ACC_W-2:7]) ? s[7:0] : 8'h80;
`endif
        end
        return (|s[ACC_W-2:7]) ? 8'h7F : s[7:0];
    endfunction

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    busy_q, busy_d;
    logic [KW-1:0]           col_q, col_d;
    logic [3:0]              nxt_w_q [H];
    logic [3:0]              nxt_w_d [H];
    logic [3:0]              cur_w_q [H];
    logic [3:0]              cur_w_d [H];
    logic [1:0]              nxt_f_q [SLICES];
    logic [1:0]              nxt_f_d [SLICES];
    logic [1:0]              cur_f_q [SLICES];
    logic [1:0]              cur_f_d [SLICES];
    logic [7:0]              nxt_a_q [W];
    logic [7:0]              nxt_a_d [W];
    logic [7:0]              cur_a_q [W];
    logic [7:0]              cur_a_d [W];
    logic signed [ACC_W-1:0] acc_q [N];
    logic signed [ACC_W-1:0] acc_d [N];
    logic signed [ACC_W-1:0] prod [H];
    logic [7:0]              oq_q [N];
    logic [7:0]              oq_d [N];
    logic [CW-1:0]           cnt_q, cnt_d;

    logic beat_acc, swap, flush_acc, last_col, snap, pop;

    assign bus.in_ready    = (state_q == ST_RUN);
    assign bus.flush_ready = (state_q == ST_RUN) && (cnt_q == '0);
    assign bus.out_valid   = (cnt_q != '0);
    assign bus.out_data    = oq_q[0];

    assign beat_acc  = bus.in_valid && bus.in_ready;
    assign swap      = beat_acc && (k_q == K_LAST);
    assign flush_acc = bus.flush && bus.flush_ready;
    assign last_col  = busy_q && (col_q == K_LAST);
    assign snap      = (state_q == ST_SNAP);
    assign pop       = bus.out_valid && bus.out_ready;

    // Flush sequencing: wait for any group still computing, then one snapshot cycle.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_acc) begin
                    state_d = (swap || (busy_q && !last_col)) ? ST_FLUSH_WAIT : ST_SNAP;
                end
            end
            ST_FLUSH_WAIT: if (!busy_q || last_col) state_d = ST_SNAP;
            ST_SNAP:       state_d = ST_RUN;
            default:       state_d = ST_RUN;
        endcase
    end

    // Beat capture into the next buffer and group swap into the current buffer.
    always_comb begin
        k_d     = k_q;
        nxt_w_d = nxt_w_q;
        nxt_f_d = nxt_f_q;
        nxt_a_d = nxt_a_q;
        cur_w_d = cur_w_q;
        cur_f_d = cur_f_q;
        cur_a_d = cur_a_q;
        if (beat_acc) begin
            for (int s = 0; s < SLICES; s++) begin
                if (k_q == KW'(s)) begin
                    nxt_w_d[2*s]   = bus.in_left[3:0];
                    nxt_w_d[2*s+1] = bus.in_left[7:4];
                    nxt_f_d[s]     = bus.fmt;
                    nxt_a_d[s]     = bus.in_top;
                end
            end
            k_d = swap ? '0 : k_q + KW'(1);
        end
        if (swap) begin
            cur_w_d = nxt_w_d;
            cur_f_d = nxt_f_d;
            cur_a_d = nxt_a_d;
        end
        // A snapshot discards any partially filled group.
        if (snap) k_d = '0;
    end

    // Compute sequencer: one column per cycle for SLICES cycles after a swap.
    always_comb begin
        busy_d = busy_q;
        col_d  = col_q;
        if (busy_q) begin
            if (last_col) busy_d = 1'b0;
            else          col_d  = col_q + KW'(1);
        end
        // A back-to-back swap lands on the last compute cycle and restarts at column 0.
        if (swap) begin
            busy_d = 1'b1;
            col_d  = '0;
        end
    end

    // H parallel multipliers on the current column's activation.
    always_comb begin
        for (int i = 0; i < H; i++) begin
            prod[i] = ACC_W'(weight_mul(cur_w_q[i], cur_f_q[i/2], cur_a_q[col_q]));
        end
    end

    // Accumulate the active column (wrapping), or clear on snapshot.
    always_comb begin
        acc_d = acc_q;
        if (snap) begin
            for (int n = 0; n < N; n++) acc_d[n] = '0;
        end else if (busy_q) begin
            for (int i = 0; i < H; i++) begin
                for (int j = 0; j < W; j++) begin
                    if (col_q == KW'(j)) acc_d[i*W+j] = acc_q[i*W+j] + prod[i];
                end
            end
        end
    end

    // Output queue: parallel load on snapshot, shift toward the head on each pop.
    always_comb begin
        oq_d  = oq_q;
        cnt_d = cnt_q;
        if (snap) begin
            for (int n = 0; n < N; n++) oq_d[n] = out_byte(acc_q[n]);
            cnt_d = CW'(N);
        end else if (pop) begin
            for (int n = 0; n < N - 1; n++) oq_d[n] = oq_q[n+1];
            oq_d[N-1] = '0;
            cnt_d     = cnt_q - CW'(1);
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: buffers, accumulators and queue are flop arrays, not RAM, so they are all reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            k_q     <= '0;
            busy_q  <= 1'b0;
            col_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < H; i++) begin
                nxt_w_q[i] <= '0;
                cur_w_q[i] <= '0;
            end
            for (int s = 0; s < SLICES; s++) begin
                nxt_f_q[s] <= '0;
                cur_f_q[s] <= '0;
                nxt_a_q[s] <= '0;
                cur_a_q[s] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                acc_q[n] <= '0;
                oq_q[n]  <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            nxt_w_q <= nxt_w_d;
            cur_w_q <= cur_w_d;
            nxt_f_q <= nxt_f_d;
            cur_f_q <= cur_f_d;
            nxt_a_q <= nxt_a_d;
            cur_a_q <= cur_a_d;
            acc_q   <= acc_d;
            oq_q    <= oq_d;
        end
    end
endmodule

// File: tb/tb_systolic_array_fmt_stream.sv
// tb_systolic_array_fmt_stream: table-driven vectors plus hand-written
// sequences for flush timing, held out_ready and mid-drain reset.
// Expected bytes go into a scoreboard queue when a flush is accepted and are
// compared as the DUT pops them. RELU_EN selects the clamped expectations.
module tb_systolic_array_fmt_stream;
    localparam int SLICES_P    = 2;
    localparam int ACC_W_P     = 24;
    localparam int OUT_SHIFT_P = 0;
    localparam int NQ          = 8;
    localparam int NV          = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_array_fmt_stream_if bus ();

    systolic_array_fmt_stream #(
        .SLICES(SLICES_P),
        .ACC_W(ACC_W_P),
        .OUT_SHIFT(OUT_SHIFT_P)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef int acc8_t [NQ];
    typedef struct packed {
        logic [1:0]           f0;
        logic [7:0]           l0;
        logic [7:0]           t0;
        logic [1:0]           f1;
        logic [7:0]           l1;
        logic [7:0]           t1;
        logic [NQ-1:0][15:0]  exp_acc;
    } vec_t;

    vec_t vecs [NV];
    int   sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Accumulator value -> byte the output stage must produce.
    function automatic int exp_byte(input int acc);
        int s;
        s = acc >>> OUT_SHIFT_P;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int idx, input logic [1:0] f0, input logic [7:0] l0, input logic [7:0] t0,
                           input logic [1:0] f1, input logic [7:0] l1, input logic [7:0] t1, input acc8_t e);
        vecs[idx].f0 = f0;
        vecs[idx].l0 = l0;
        vecs[idx].t0 = t0;
        vecs[idx].f1 = f1;
        vecs[idx].l1 = l1;
        vecs[idx].t1 = t1;
        for (int n = 0; n < NQ; n++) vecs[idx].exp_acc[n] = 16'(e[n]);
    endtask

    task automatic send_beat(input logic [1:0] f, input logic [7:0] l, input logic [7:0] t);
        int n;
        n = 0;
        bus.fmt      = f;
        bus.in_left  = l;
        bus.in_top   = t;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: in_ready low for %0d cycles, required high", n);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush(input acc8_t e);
        int n;
        n = 0;
        while (!bus.flush_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL flush_timeout: flush_ready low for %0d cycles, required high", n);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < NQ; i++) sb.push_back(exp_byte(e[i]));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", (sb.size() == 0 && !bus.out_valid) ? 1 : 0, 1);
    endtask

    // Scoreboard monitor: every byte the DUT hands over at the next edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got byte %0d, required no output", $signed(bus.out_data));
            end else begin
                int e;
                e = sb.pop_front();
                check("out_data", $signed(bus.out_data), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        acc8_t e;
        int    n;

        reset         = 1'b1;
        bus.fmt       = 2'd0;
        bus.in_valid  = 1'b0;
        bus.in_left   = 8'h00;
        bus.in_top    = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        add_vec(0, 2'd0, 8'h11, 8'd3,  2'd0, 8'h11, 8'd5,  '{6, 10, 6, 10, 6, 10, 6, 10});
        add_vec(1, 2'd1, 8'hFF, 8'h80, 2'd1, 8'hFF, 8'h80, '{128, 128, 128, 128, 128, 128, 128, 128});
        add_vec(2, 2'd1, 8'h11, 8'hFB, 2'd1, 8'h11, 8'hFB, '{-5, -5, -5, -5, -5, -5, -5, -5});
        add_vec(3, 2'd2, 8'h77, 8'd10, 2'd2, 8'h77, 8'd10, '{120, 120, 120, 120, 120, 120, 120, 120});
        add_vec(4, 2'd1, 8'h87, 8'd4,  2'd1, 8'h2E, 8'hFD, '{28, -21, -32, 24, -8, 6, 8, -6});
        add_vec(5, 2'd0, 8'hF7, 8'd1,  2'd0, 8'h08, 8'hFF, '{128, -128, -128, 128, 0, 0, 0, 0});
        add_vec(6, 2'd3, 8'h77, 8'd10, 2'd3, 8'h77, 8'd10, '{0, 0, 0, 0, 0, 0, 0, 0});
        add_vec(7, 2'd2, 8'h91, 8'd7,  2'd2, 8'h5C, 8'hFE, '{7, -2, -7, 2, -28, 8, 42, -12});
        add_vec(8, 2'd1, 8'h33, 8'd2,  2'd0, 8'h33, 8'd5,  '{6, 15, 6, 15, 16, 40, 16, 40});

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_flush_ready", bus.flush_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        reset = 1'b0;
        tick();

        // Idle flush: snapshot cycle, valid next cycle, drain of H*W cycles
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("snap_in_ready", bus.in_ready, 0);
        check("snap_out_valid", bus.out_valid, 0);
        check("snap_flush_ready", bus.flush_ready, 0);
        for (int i = 0; i < NQ; i++) sb.push_back(exp_byte(0));
        tick();
        check("post_snap_out_valid", bus.out_valid, 1);
        check("post_snap_in_ready", bus.in_ready, 1);
        n = 0;
        while (!bus.flush_ready && n < 50) begin
            tick();
            n++;
        end
        check("drain_cycles", n, NQ);
        wait_drain();

        // Table-driven vectors
        for (int v = 0; v < NV; v++) begin
            send_beat(vecs[v].f0, vecs[v].l0, vecs[v].t0);
            send_beat(vecs[v].f1, vecs[v].l1, vecs[v].t1);
            for (int i = 0; i < NQ; i++) e[i] = int'($signed(vecs[v].exp_acc[i]));
            do_flush(e);
            wait_drain();
        end

        // Flush on the same edge as the group-completing beat
        send_beat(2'd1, 8'h11, 8'd9);
        bus.fmt      = 2'd1;
        bus.in_left  = 8'h11;
        bus.in_top   = 8'hF7;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        check("coinc_in_ready", bus.in_ready, 1);
        check("coinc_flush_ready", bus.flush_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        for (int i = 0; i < NQ; i++) sb.push_back(exp_byte((i % 2 == 0) ? 9 : -9));
        for (int c = 0; c < 4; c++) begin
            check($sformatf("coinc_in_ready_c%0d", c), bus.in_ready, (c < 3) ? 0 : 1);
            if (c < 3) tick();
        end
        check("coinc_out_valid", bus.out_valid, 1);
        wait_drain();

        // Two groups accumulate; drain with out_ready toggling; reset mid-drain
        repeat (2) begin
            send_beat(2'd0, 8'h11, 8'd3);
            send_beat(2'd0, 8'h11, 8'd5);
        end
        bus.out_ready = 1'b0;
        do_flush('{12, 20, 12, 20, 12, 20, 12, 20});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("toggle_valid", bus.out_valid, 1);
        for (int c = 0; c < 6; c++) begin
            bus.out_ready = (c % 2 == 1);
            tick();
            if (c % 2 == 0) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", $signed(bus.out_data), sb[0]);
            end
        end
        check("toggle_remaining", sb.size(), 5);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_flush_ready", bus.flush_ready, 1);
        repeat (2) tick();
        check("midrst_queue_empty", bus.out_valid, 0);

        // A new group accumulates while the previous snapshot drains
        send_beat(2'd0, 8'h11, 8'd3);
        send_beat(2'd0, 8'h11, 8'd5);
        do_flush('{6, 10, 6, 10, 6, 10, 6, 10});
        send_beat(2'd1, 8'h11, 8'd2);
        send_beat(2'd1, 8'h11, 8'd3);
        check("overlap_draining", bus.out_valid, 1);
        do_flush('{2, 3, 2, 3, 2, 3, 2, 3});
        wait_drain();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
